// File: rtl/i2c_apb_sequencer.sv
// i2c_apb_sequencer: APB master that runs whole I2C transactions on the I2C master subsystem
module i2c_apb_sequencer #(
    parameter logic [7:0] ADDR_PRESCALE = 8'h00,
    parameter logic [7:0] ADDR_COMMAND  = 8'h01,
    parameter logic [7:0] ADDR_STATUS   = 8'h02,
    parameter logic [7:0] ADDR_TRANSMIT = 8'h03,
    parameter logic [7:0] ADDR_RECEIVE  = 8'h04,
    parameter logic [7:0] ADDR_ADDRESS  = 8'h05,
    parameter int         TIMEOUT       = 1023
) (
    input  logic       PCLK,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [2:0] req_len,
    input  logic [7:0] req_prescale,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       done,
    output logic       error,
    output logic       PSELx,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY
);
    localparam logic [7:0] BASE     = 8'h10;
    localparam logic [9:0] POLL_MAX = 10'(TIMEOUT - 1);

    typedef enum logic [4:0] {
        S_IDLE, S_CFG_PRE, S_CFG_ADR, S_CFG_CMD, S_LD_POLL, S_LD_TX, S_LD_WR, S_LD_PUSH,
        S_LD_CLR, S_START, S_WR_POLL, S_RD_POLL, S_RD_POP, S_RD_EN, S_RD_DATA, S_RD_OUT,
        S_END, S_FINISH, S_ABORT, S_ERR
    } state_t;
    typedef enum logic [1:0] {AP_IDLE, AP_SETUP, AP_ACCESS} apb_t;

    state_t     state, state_n;
    apb_t       apb, apb_n;
    logic       rw;
    logic [6:0] addr;
    logic [2:0] len, cnt;
    logic [7:0] pre, tx_byte, rx_byte;
    logic [9:0] polls;
    logic       acc, fin, last, expired, poll, poll_ok;

    assign fin       = apb == AP_ACCESS && PREADY;
    assign last      = cnt == len;
    assign expired   = polls == POLL_MAX;
    assign req_ready = state == S_IDLE;
    assign tx_ready  = state == S_LD_TX;
    assign rx_valid  = state == S_RD_OUT;
    assign rx_data   = rx_byte;
    assign done      = state == S_FINISH || state == S_ERR;
    assign error     = state == S_ERR;
    assign PSELx     = apb != AP_IDLE;
    assign PENABLE   = apb == AP_ACCESS;
    assign apb_n     = apb == AP_SETUP ? AP_ACCESS :
                       apb == AP_ACCESS ? (PREADY ? AP_IDLE : AP_ACCESS) :
                       acc ? AP_SETUP : AP_IDLE;

    // Each step owns one APB access; the state only advances on that access's PREADY cycle.
    always_comb begin
        state_n = state;
        acc     = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        poll    = 1'b0;
        poll_ok = 1'b0;
        case (state)
            S_IDLE:    state_n = req_valid ? S_CFG_PRE : S_IDLE;
            S_CFG_PRE: begin
                acc = 1'b1; PWRITE = 1'b1; PADDR = ADDR_PRESCALE; PWDATA = pre;
                if (fin) state_n = S_CFG_ADR;
            end
            S_CFG_ADR: begin
                acc = 1'b1; PWRITE = 1'b1; PADDR = ADDR_ADDRESS; PWDATA = {addr, rw};
                if (fin) state_n = S_CFG_CMD;
            end
            S_CFG_CMD: begin
                acc = 1'b1; PWRITE = 1'b1; PADDR = ADDR_COMMAND; PWDATA = BASE;
                if (fin) state_n = S_LD_POLL;
            end
            S_LD_POLL: begin
                acc = 1'b1; poll = 1'b1; PADDR = ADDR_STATUS; poll_ok = !PRDATA[7];
                if (fin) state_n = poll_ok ? (rw ? S_LD_WR : S_LD_TX) : expired ? S_ABORT : S_LD_POLL;
            end
            S_LD_TX:   state_n = tx_valid ? S_LD_WR : S_LD_TX;
            S_LD_WR: begin
                acc = 1'b1; PWRITE = 1'b1; PADDR = ADDR_TRANSMIT; PWDATA = rw ? 8'h00 : tx_byte;
                if (fin) state_n = S_LD_PUSH;
            end
            S_LD_PUSH: begin
                acc = 1'b1; PWRITE = 1'b1; PADDR = ADDR_COMMAND; PWDATA = BASE | 8'h40;
                if (fin) state_n = S_LD_CLR;
            end
            S_LD_CLR: begin
                acc = 1'b1; PWRITE = 1'b1; PADDR = ADDR_COMMAND; PWDATA = BASE;
                if (fin) state_n = last ? S_START : S_LD_POLL;
            end
            S_START: begin
                acc = 1'b1; PWRITE = 1'b1; PADDR = ADDR_COMMAND; PWDATA = BASE | 8'h80;
                if (fin) state_n = rw ? S_RD_POLL : S_WR_POLL;
            end
            S_WR_POLL: begin
                acc = 1'b1; poll = 1'b1; PADDR = ADDR_STATUS; poll_ok = PRDATA[6];
                if (fin) state_n = poll_ok ? S_END : expired ? S_ABORT : S_WR_POLL;
            end
            S_RD_POLL: begin
                acc = 1'b1; poll = 1'b1; PADDR = ADDR_STATUS; poll_ok = !PRDATA[4];
                if (fin) state_n = poll_ok ? S_RD_POP : expired ? S_ABORT : S_RD_POLL;
            end
            S_RD_POP: begin
                acc = 1'b1; PWRITE = 1'b1; PADDR = ADDR_COMMAND; PWDATA = BASE | 8'hA0;
                if (fin) state_n = S_RD_EN;
            end
            S_RD_EN: begin
                acc = 1'b1; PWRITE = 1'b1; PADDR = ADDR_COMMAND; PWDATA = BASE | 8'h80;
                if (fin) state_n = S_RD_DATA;
            end
            S_RD_DATA: begin
                acc = 1'b1; PADDR = ADDR_RECEIVE;
                if (fin) state_n = S_RD_OUT;
            end
            S_RD_OUT:  state_n = rx_ready ? (last ? S_END : S_RD_POLL) : S_RD_OUT;
            S_END: begin
                acc = 1'b1; PWRITE = 1'b1; PADDR = ADDR_COMMAND; PWDATA = BASE;
                if (fin) state_n = S_FINISH;
            end
            S_ABORT: begin
                acc = 1'b1; PWRITE = 1'b1; PADDR = ADDR_COMMAND; PWDATA = 8'h00;
                if (fin) state_n = S_ERR;
            end
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (rst) begin
            state   <= S_IDLE;
            apb     <= AP_IDLE;
            rw      <= 1'b0;
            addr    <= '0;
            len     <= '0;
            pre     <= '0;
            cnt     <= '0;
            polls   <= '0;
            tx_byte <= '0;
            rx_byte <= '0;
        end else begin
            state <= state_n;
            apb   <= apb_n;
            if (state == S_IDLE && req_valid) begin
                rw    <= req_rw;
                addr  <= req_addr;
                len   <= req_len;
                pre   <= req_prescale;
                cnt   <= '0;
                polls <= '0;
            end
            if (poll && fin) polls <= poll_ok ? '0 : polls + 10'd1;
            if (state == S_LD_TX && tx_valid) tx_byte <= tx_data;
            if (state == S_RD_DATA && fin) rx_byte <= PRDATA;
            if ((state == S_LD_CLR && fin) || (state == S_RD_OUT && rx_ready)) cnt <= last ? '0 : cnt + 3'd1;
        end
    end
endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// tb_i2c_apb_sequencer: directed bench with an APB slave and a transaction-level model of the expected bus traffic
module tb_i2c_apb_sequencer;
    localparam logic [7:0] A_PRE = 8'h00, A_CMD = 8'h01, A_STA = 8'h02;
    localparam logic [7:0] A_TX = 8'h03, A_RX = 8'h04, A_ADR = 8'h05;

    logic       PCLK = 1'b0, rst = 1'b1;
    logic       req_valid = 1'b0, req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [2:0] req_len = '0;
    logic [7:0] req_prescale = '0;
    logic       tx_valid = 1'b0, rx_ready = 1'b1, PREADY = 1'b1;
    logic [7:0] tx_data = '0, PRDATA = '0;
    logic       req_ready, tx_ready, rx_valid, done, error, PSELx, PENABLE, PWRITE;
    logic [7:0] rx_data, PADDR, PWDATA;

    i2c_apb_sequencer dut (
        .PCLK(PCLK), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_len(req_len), .req_prescale(req_prescale),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .done(done), .error(error), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
    } acc_t;

    acc_t       exp_q[$];
    logic [7:0] rx_src[$], rx_exp[$], tx_bytes[$];
    int checks = 0, errors = 0;
    int waits = 0, busy = 0, stall_left = 0, poll_ctr = 0, en_cyc = 0;
    int tx_idx = 0, tx_beats = 0, rx_cnt = 0, done_cnt = 0;
    logic force_full = 1'b0, tx_hs = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
        acc_t e;
        e.w = w; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic poll_n();
        for (int k = 0; k <= busy; k++) push(1'b0, A_STA, 8'h00);
    endtask

    // Expected APB traffic for one descriptor, derived from the transaction rules.
    task automatic build(input logic rw, input logic [6:0] a, input logic [2:0] len, input logic [7:0] pre, input logic to);
        push(1'b1, A_PRE, pre);
        push(1'b1, A_ADR, {a, rw});
        push(1'b1, A_CMD, 8'h10);
        if (to) begin
            for (int i = 0; i < 1023; i++) push(1'b0, A_STA, 8'h00);
            push(1'b1, A_CMD, 8'h00);
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                poll_n();
                push(1'b1, A_TX, rw ? 8'h00 : tx_bytes[i]);
                push(1'b1, A_CMD, 8'h50);
                push(1'b1, A_CMD, 8'h10);
            end
            push(1'b1, A_CMD, 8'h90);
            if (!rw) poll_n();
            else for (int i = 0; i <= int'(len); i++) begin
                poll_n();
                push(1'b1, A_CMD, 8'hB0);
                push(1'b1, A_CMD, 8'h90);
                push(1'b0, A_RX, 8'h00);
            end
            push(1'b1, A_CMD, 8'h10);
        end
    endtask

    task automatic slave_rd(output logic [7:0] v);
        if (PADDR == A_STA) begin
            if (force_full) v = 8'h80;
            else if (poll_ctr < busy) begin poll_ctr++; v = 8'hB0; end
            else begin poll_ctr = 0; v = 8'h40; end
        end else if (PADDR == A_RX && rx_src.size() > 0) v = rx_src.pop_front();
        else v = 8'h00;
    endtask

    task automatic prep();
        exp_q.delete(); rx_src.delete(); rx_exp.delete(); tx_bytes.delete();
        tx_idx = 0; tx_hs = 1'b0; tx_beats = 0; rx_cnt = 0; done_cnt = 0; poll_ctr = 0; stall_left = 0;
    endtask

    // Slave, stream endpoints and per-cycle compare, all evaluated on the falling edge.
    initial begin : bus
        acc_t       e;
        logic [7:0] v;
        forever begin
            @(negedge PCLK);
            if (tx_hs) tx_idx++;
            tx_valid = tx_idx < tx_bytes.size();
            tx_data = tx_valid ? tx_bytes[tx_idx] : 8'h00;
            tx_hs = tx_valid && tx_ready;
            if (tx_hs) tx_beats++;
            if (PSELx && PENABLE) begin
                en_cyc++;
                PREADY = en_cyc > waits;
                if (PREADY && !PWRITE) begin slave_rd(v); PRDATA = v; end
            end else begin
                en_cyc = 0;
                PREADY = waits == 0;
                PRDATA = 8'h00;
            end
            if (PENABLE) chk("penable_without_psel", PSELx, 1);
            if (PSELx && PENABLE && PREADY) begin
                chk("penable_len", en_cyc, waits + 1);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL apb_extra actual w=%0b addr=%0h data=%0h required none", PWRITE, PADDR, PWDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("apb_write", PWRITE, e.w);
                    chk("apb_addr", PADDR, e.a);
                    if (e.w) chk("apb_wdata", PWDATA, e.d);
                end
            end
            if (rx_valid) begin
                if (stall_left > 0) begin
                    rx_ready = 1'b0;
                    stall_left--;
                    chk("stall_psel", PSELx, 0);
                    if (rx_exp.size() > 0) chk("stall_data", rx_data, rx_exp[0]);
                end else rx_ready = 1'b1;
                if (rx_ready) begin
                    rx_cnt++;
                    if (rx_exp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rx_extra actual=%0h required none", rx_data);
                    end else chk("rx_data", rx_data, rx_exp.pop_front());
                end
            end else rx_ready = 1'b1;
            if (done) done_cnt++;
            if (error) chk("error_with_done", done, 1);
        end
    end

    task automatic go(input logic rw, input logic [6:0] a, input logic [2:0] len, input logic [7:0] pre,
                      input logic exp_err, input int exp_tx, input int exp_rx);
        int n = 0;
        @(negedge PCLK);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_len = len; req_prescale = pre;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            chk("busy_not_ready", req_ready, 0);
            req_addr = ~req_addr; req_rw = ~req_rw; req_len = 3'd7;
        end
        req_valid = 1'b0;
        while (!done && n < 20000) begin @(negedge PCLK); n++; end
        chk("done_seen", done, 1);
        chk("error_flag", error, exp_err);
        @(negedge PCLK);
        chk("ready_after_done", req_ready, 1);
        chk("done_one_cycle", done, 0);
        #1;
        chk("apb_missing", exp_q.size(), 0);
        chk("done_count", done_cnt, 1);
        chk("tx_beats", tx_beats, exp_tx);
        chk("rx_count", rx_cnt, exp_rx);
        chk("rx_left", rx_exp.size(), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge PCLK);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_psel", PSELx, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_paddr", PADDR, 0);
        rst = 1'b0;

        tx_bytes = '{8'hA5, 8'h3C, 8'hFF};
        build(1'b0, 7'h50, 3'd2, 8'h04, 1'b0);
        chk("model_wr_size", exp_q.size(), 18);
        chk("model_wr_addr", exp_q[1].d, 8'hA0);
        chk("model_wr_byte0", exp_q[4].d, 8'hA5);
        chk("model_wr_push", exp_q[5].d, 8'h50);
        go(1'b0, 7'h50, 3'd2, 8'h04, 1'b0, 3, 0);

        prep();
        rx_src = '{8'h5A, 8'hC3}; rx_exp = '{8'h5A, 8'hC3}; tx_bytes = '{8'hEE};
        build(1'b1, 7'h21, 3'd1, 8'h10, 1'b0);
        chk("model_rd_size", exp_q.size(), 21);
        chk("model_rd_addr", exp_q[1].d, 8'h43);
        chk("model_rd_dummy", exp_q[4].d, 8'h00);
        go(1'b1, 7'h21, 3'd1, 8'h10, 1'b0, 0, 2);

        prep();
        waits = 3;
        tx_bytes = '{8'hA5, 8'h3C, 8'hFF};
        build(1'b0, 7'h50, 3'd2, 8'h04, 1'b0);
        go(1'b0, 7'h50, 3'd2, 8'h04, 1'b0, 3, 0);

        prep();
        waits = 0;
        rx_src = '{8'h5A, 8'hC3}; rx_exp = '{8'h5A, 8'hC3};
        build(1'b1, 7'h21, 3'd1, 8'h10, 1'b0);
        stall_left = 20;
        go(1'b1, 7'h21, 3'd1, 8'h10, 1'b0, 0, 2);
        chk("stall_consumed", stall_left, 0);

        prep();
        busy = 2; waits = 1;
        tx_bytes = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        build(1'b0, 7'h7F, 3'd7, 8'hFF, 1'b0);
        go(1'b0, 7'h7F, 3'd7, 8'hFF, 1'b0, 8, 0);

        prep();
        busy = 1; waits = 2;
        rx_src = '{8'h00, 8'hFF, 8'h96}; rx_exp = '{8'h00, 8'hFF, 8'h96};
        build(1'b1, 7'h00, 3'd2, 8'h80, 1'b0);
        go(1'b1, 7'h00, 3'd2, 8'h80, 1'b0, 0, 3);

        prep();
        busy = 0; waits = 0; force_full = 1'b1;
        tx_bytes = '{8'h12};
        build(1'b0, 7'h33, 3'd0, 8'h02, 1'b1);
        chk("model_to_size", exp_q.size(), 1027);
        go(1'b0, 7'h33, 3'd0, 8'h02, 1'b1, 0, 0);
        force_full = 1'b0;

        prep();
        waits = 3;
        tx_bytes = '{8'h11, 8'h22};
        build(1'b0, 7'h0A, 3'd1, 8'h08, 1'b0);
        @(negedge PCLK);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h0A; req_len = 3'd1; req_prescale = 8'h08;
        @(negedge PCLK);
        req_valid = 1'b0;
        n = 0;
        while (!(PSELx && PENABLE) && n < 100) begin @(negedge PCLK); n++; end
        chk("reach_access", PSELx && PENABLE, 1);
        rst = 1'b1;
        @(negedge PCLK);
        rst = 1'b0;
        chk("mid_rst_psel", PSELx, 0);
        chk("mid_rst_penable", PENABLE, 0);
        chk("mid_rst_ready", req_ready, 1);
        #1;
        prep();
        waits = 0;
        tx_bytes = '{8'h11, 8'h22};
        build(1'b0, 7'h0A, 3'd1, 8'h08, 1'b0);
        go(1'b0, 7'h0A, 3'd1, 8'h08, 1'b0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
